sha256_block_sequencer: RTL and testbench

SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

---
 rtl/sha256_block_sequencer.sv | 175 +++++++++++++++++
 tb/tb_sha256_block_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_sequencer.sv
// Sequences pre-padded 512-bit blocks from word memory through an external SHA-256
// compression core and writes the final 8-word digest back to memory.
`timescale 1ns/1ps
module sha256_block_sequencer #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [7:0]        num_blocks,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              core_start,
  output logic [15:0][31:0] core_block,
  output logic [7:0][31:0]  core_hash,
  input  logic              core_done,
  input  logic [7:0][31:0]  core_digest
);

  localparam int unsigned BLK_WORDS  = 16;
  localparam int unsigned HASH_WORDS = 8;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned BLK_W      = 8;

  localparam logic [7:0][31:0] H_INIT = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, WRITE, FIN} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [BLK_W-1:0]  nblk_q, nblk_d;
  logic [ADDR_W-1:0] msg_addr_q, msg_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_start_q, core_start_d;
  logic [15:0][31:0] core_block_q, core_block_d;
  logic [7:0][31:0]  core_hash_q, core_hash_d;

  logic wait_armed;
  logic last_blk;
  logic blk_complete;

  // The first WAIT cycle may still see the core's stale idle level from the previous run
  assign wait_armed   = (cnt_q != '0);
  assign last_blk     = (BLK_W'(blk_q + 8'd1) == nblk_q);
  assign blk_complete = (state_q == WAIT) && wait_armed && core_done;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (num_blocks == '0) ? FIN : LOAD;
      LOAD:    if (cnt_q == CNT_W'(BLK_WORDS)) state_d = KICK;
      KICK:    state_d = WAIT;
      WAIT:    if (wait_armed && core_done) state_d = last_blk ? WRITE : LOAD;
      WRITE:   if (cnt_q == CNT_W'(HASH_WORDS - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs, computed from the upcoming state so they align with it
  always_comb begin
    cnt_d        = cnt_q;
    blk_d        = blk_q;
    nblk_d       = nblk_q;
    msg_addr_d   = msg_addr_q;
    out_addr_d   = out_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_block_d = core_block_q;
    core_hash_d  = core_hash_q;
    busy_d       = (state_d != IDLE);
    done_d       = (state_q == FIN);
    core_start_d = (state_d == KICK);
    mem_we_d     = (state_d == WRITE);

    if ((state_q == IDLE) && start) begin
      msg_addr_d  = message_addr;
      nblk_d      = num_blocks;
      out_addr_d  = output_addr;
      core_hash_d = H_INIT;
      blk_d       = '0;
    end

    // Read data lags the presented address by one cycle
    if ((state_q == LOAD) && (cnt_q != '0)) begin
      core_block_d[4'(cnt_q - 5'd1)] = mem_read_data;
    end

    if (blk_complete) begin
      core_hash_d = core_digest;
      blk_d       = BLK_W'(blk_q + 8'd1);
    end

    if (state_d != state_q)                         cnt_d = '0;
    else if (state_q == WAIT)                       cnt_d = CNT_W'(1);
    else if ((state_q == LOAD) || (state_q == WRITE)) cnt_d = CNT_W'(cnt_q + 5'd1);

    // Address arithmetic wraps naturally at ADDR_W bits
    if ((state_d == LOAD) && (cnt_d < CNT_W'(BLK_WORDS))) begin
      mem_addr_d = msg_addr_d + ADDR_W'({blk_d, 4'b0000}) + ADDR_W'(cnt_d);
    end

    if (state_d == WRITE) begin
      mem_addr_d  = out_addr_d + ADDR_W'(cnt_d);
      mem_wdata_d = core_hash_d[cnt_d[2:0]];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      blk_q        <= '0;
      nblk_q       <= '0;
      msg_addr_q   <= '0;
      out_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      core_start_q <= 1'b0;
      core_block_q <= '0;
      core_hash_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      nblk_q       <= nblk_d;
      msg_addr_q   <= msg_addr_d;
      out_addr_q   <= out_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      core_start_q <= core_start_d;
      core_block_q <= core_block_d;
      core_hash_q  <= core_hash_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_addr       = mem_addr_q;
  assign mem_we         = mem_we_q;
  assign mem_write_data = mem_wdata_q;
  assign core_start     = core_start_q;
  assign core_block     = core_block_q;
  assign core_hash      = core_hash_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer: word memory, a behavioural SHA-256
// compression core with a one-cycle start delay, and known-answer digests.
`timescale 1ns/1ps
module tb_sha256_block_sequencer;

  localparam int unsigned ADDR_W = 16;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] ABC_DIG [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };
  localparam logic [31:0] TWO_DIG [8] = '{
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
  };
  localparam logic [31:0] SENTINEL = 32'h5a5a5a5a;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] message_addr;
  logic [7:0]        num_blocks;
  logic [ADDR_W-1:0] output_addr;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  logic              core_start;
  logic [15:0][31:0] core_block;
  logic [7:0][31:0]  core_hash;
  logic              core_done;
  logic [7:0][31:0]  core_digest;

  sha256_block_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .message_addr   (message_addr),
    .num_blocks     (num_blocks),
    .output_addr    (output_addr),
    .busy           (busy),
    .done           (done),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .core_start     (core_start),
    .core_block     (core_block),
    .core_hash      (core_hash),
    .core_done      (core_done),
    .core_digest    (core_digest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // SHA-256 helpers for the core model
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0][31:0] sha_compress(input logic [7:0][31:0] h, input logic [15:0][31:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    logic [7:0][31:0] r;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
    r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
    return r;
  endfunction

  // Word memory: registered read, DUT writes and bench preloads share one port
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              tb_we;
  logic [ADDR_W-1:0] tb_waddr;
  logic [31:0]       tb_wdata;

  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr];
    if (tb_we)       mem[tb_waddr] <= tb_wdata;
    else if (mem_we) mem[mem_addr] <= mem_write_data;
  end

  // Core model: drops core_done one cycle after the start pulse, digest garbled while running
  int               core_lat;
  int               core_cnt;
  logic             start_seen;
  logic [7:0][31:0] core_res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_done   <= 1'b1;
      core_digest <= '0;
      start_seen  <= 1'b0;
      core_cnt    <= 0;
      core_res    <= '0;
    end else begin
      start_seen <= core_start;
      if (core_start) core_res <= sha_compress(core_hash, core_block);
      if (start_seen) begin
        core_done   <= 1'b0;
        core_cnt    <= core_lat;
        core_digest <= {8{32'hdeadbeef}};
      end else if (!core_done) begin
        if (core_cnt == 0) begin
          core_done   <= 1'b1;
          core_digest <= core_res;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  int               n_writes = 0;
  int               n_starts = 0;
  int               n_dones  = 0;
  logic [15:0][31:0] blk_snap;

  always @(posedge clk) begin
    if (mem_we) n_writes <= n_writes + 1;
    if (core_start) begin
      n_starts <= n_starts + 1;
      blk_snap <= core_block;
    end
    if (done) n_dones <= n_dones + 1;
  end

  task automatic poke(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    tb_we = 1'b1; tb_waddr = addr; tb_wdata = data;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic load_abc(input logic [ADDR_W-1:0] base);
    for (int k = 0; k < 16; k++) begin
      poke(ADDR_W'(base + ADDR_W'(k)), (k == 0) ? 32'h61626380 : (k == 15) ? 32'h00000018 : 32'h0);
    end
  endtask

  task automatic load_two(input logic [ADDR_W-1:0] base);
    logic [7:0] c;
    for (int k = 0; k < 14; k++) begin
      c = 8'(8'h61 + k);
      poke(ADDR_W'(base + ADDR_W'(k)), {c, 8'(c + 8'd1), 8'(c + 8'd2), 8'(c + 8'd3)});
    end
    poke(ADDR_W'(base + 16'd14), 32'h80000000);
    poke(ADDR_W'(base + 16'd15), 32'h0);
    for (int k = 16; k < 31; k++) poke(ADDR_W'(base + ADDR_W'(k)), 32'h0);
    poke(ADDR_W'(base + 16'd31), 32'h000001c0);
  endtask

  // Called #1 after an edge; start is sampled at the next edge, then inputs wander
  task automatic start_job(input logic [ADDR_W-1:0] maddr, input logic [7:0] nblk, input logic [ADDR_W-1:0] oaddr);
    message_addr = maddr; num_blocks = nblk; output_addr = oaddr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; message_addr = 16'hbeef; num_blocks = 8'd7; output_addr = 16'h0bad;
  endtask

  // Cycle 1 is the cycle right after the edge that sampled start
  task automatic wait_done(input int cyc0, output int kick_cyc, output int done_cyc);
    int cyc;
    cyc = cyc0;
    kick_cyc = 0;
    while (done !== 1'b1 && cyc < 600) begin
      if (core_start === 1'b1 && kick_cyc == 0) kick_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    done_cyc = cyc;
    check("done_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_digest(input string tag, input logic [ADDR_W-1:0] oaddr, input logic [31:0] exp [8]);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_w%0d", tag, k), mem[ADDR_W'(oaddr + ADDR_W'(k))], exp[k]);
    end
  endtask

  task automatic wait_core_busy(output int cyc);
    cyc = 1;
    while (core_done !== 1'b0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_wait", 32'(core_done), 32'd0);
  endtask

  int kick_cyc, done_cyc, cyc;
  int w0, s0, d0;

  initial begin
    n_checks = 0; n_fail = 0;
    start = 1'b0; reset_n = 1'b1;
    message_addr = '0; num_blocks = '0; output_addr = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    core_lat = 3;

    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_hash0", core_hash[0], 32'd0);
    check("rst_block15", core_block[15], 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    poke(16'h0bad, SENTINEL);

    // Single block "abc"
    load_abc(16'h0000);
    w0 = n_writes; s0 = n_starts; d0 = n_dones;
    start_job(16'h0000, 8'd1, 16'h0100);
    check("abc_busy", 32'(busy), 32'd1);
    wait_done(1, kick_cyc, done_cyc);
    check("abc_kick_cycle", 32'(kick_cyc), 32'd18);
    check("abc_writes", 32'(n_writes - w0), 32'd8);
    check("abc_starts", 32'(n_starts - s0), 32'd1);
    check("abc_dones", 32'(n_dones - d0), 32'd1);
    check_digest("abc", 16'h0100, ABC_DIG);
    check("live_input_unused", mem[16'h0bad], SENTINEL);

    // Two-block message
    core_lat = 5;
    load_two(16'h0200);
    w0 = n_writes; s0 = n_starts; d0 = n_dones;
    start_job(16'h0200, 8'd2, 16'h0300);
    wait_done(1, kick_cyc, done_cyc);
    check("two_kick_cycle", 32'(kick_cyc), 32'd18);
    check("two_writes", 32'(n_writes - w0), 32'd8);
    check("two_starts", 32'(n_starts - s0), 32'd2);
    check("two_dones", 32'(n_dones - d0), 32'd1);
    check_digest("two", 16'h0300, TWO_DIG);

    // Zero blocks
    w0 = n_writes; s0 = n_starts; d0 = n_dones;
    start_job(16'h0000, 8'd0, 16'h0800);
    check("zero_busy", 32'(busy), 32'd1);
    wait_done(1, kick_cyc, done_cyc);
    check("zero_done_cycle", 32'(done_cyc), 32'd2);
    check("zero_writes", 32'(n_writes - w0), 32'd0);
    check("zero_starts", 32'(n_starts - s0), 32'd0);
    check("zero_dones", 32'(n_dones - d0), 32'd1);

    // Start during WAIT is ignored
    core_lat = 4;
    poke(16'h0500, SENTINEL);
    w0 = n_writes; s0 = n_starts;
    start_job(16'h0000, 8'd1, 16'h0400);
    wait_core_busy(cyc);
    message_addr = 16'h0200; num_blocks = 8'd2; output_addr = 16'h0500; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    wait_done(cyc + 1, kick_cyc, done_cyc);
    check("restart_writes", 32'(n_writes - w0), 32'd8);
    check("restart_starts", 32'(n_starts - s0), 32'd1);
    check("restart_second_out", mem[16'h0500], SENTINEL);
    check_digest("restart", 16'h0400, ABC_DIG);

    // Reset during WAIT abandons the job
    poke(16'h0700, SENTINEL);
    w0 = n_writes;
    start_job(16'h0000, 8'd1, 16'h0700);
    wait_core_busy(cyc);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_core_start", 32'(core_start), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_hash0", core_hash[0], 32'd0);
    check("mid_rst_block0", core_block[0], 32'd0);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("mid_rst_no_writes", 32'(n_writes - w0), 32'd0);
    check("mid_rst_out_intact", mem[16'h0700], SENTINEL);
    check("mid_rst_idle", 32'(busy), 32'd0);
    start_job(16'h0000, 8'd1, 16'h0700);
    wait_done(1, kick_cyc, done_cyc);
    check_digest("after_rst", 16'h0700, ABC_DIG);

    // Message straddling the top of the address space
    core_lat = 2;
    load_abc(16'hfff8);
    w0 = n_writes;
    start_job(16'hfff8, 8'd1, 16'h0600);
    wait_done(1, kick_cyc, done_cyc);
    check("wrap_blk0", blk_snap[0], 32'h61626380);
    check("wrap_blk15", blk_snap[15], 32'h00000018);
    check("wrap_writes", 32'(n_writes - w0), 32'd8);
    check_digest("wrap", 16'h0600, ABC_DIG);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
